// File: rtl/pingpong_bank_ctrl.sv
// Two-bank ping-pong buffer controller: the writer fills one bank while the reader drains the other.
// Define PINGPONG_IDX_CHK_EN to build the per-bank duplicate-index checker that drives err.
module pingpong_bank_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    input  logic [AW-1:0] wr_idx,
    output logic          wr_ready,
    output logic          wr_bank,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic          rd_bank,
    output logic [AW-1:0] rd_addr,
    output logic          mem0_lock,
    output logic          mem1_lock,
    output logic          mem0_empty,
    output logic          mem1_empty,
    output logic          err
);

    typedef enum logic [2:0] {
        WR0     = 3'b001,
        WR1     = 3'b010,
        WRSTALL = 3'b100
    } wrState_t;

    typedef enum logic [2:0] {
        RDIDLE = 3'b001,
        RD0    = 3'b010,
        RD1    = 3'b100
    } rdState_t;

    localparam logic [AW:0]   WR_LAST = (AW+1)'(DEPTH - 1);
    localparam logic [AW-1:0] RD_LAST = AW'(DEPTH - 1);

    wrState_t      wrState_q;
    logic          nextBank_q;
    logic [AW:0]   wrCnt_q [2];
    rdState_t      rdState_q;
    logic          expBank_q;
    logic [AW-1:0] rdAddr_q;
    logic [1:0]    lock_q;
    logic [1:0]    empty_q;

    logic wrAccept;
    logic wrFill;
    logic rdCurBank;
    logic rdPop;
    logic rdDrain;

    always_comb begin
        wrAccept  = wr_valid && wr_ready;
        wrFill    = wrAccept && (wrCnt_q[nextBank_q] == WR_LAST);
        rdCurBank = (rdState_q == RD1);
        rdPop     = rd_valid && rd_ready;
        rdDrain   = rdPop && (rdAddr_q == RD_LAST);
    end

    // nextBank_q is the bank being written, or the bank awaited while stalled.
    assign wr_ready   = (wrState_q == WR0) || (wrState_q == WR1);
    assign wr_bank    = nextBank_q;
    assign rd_valid   = (rdState_q == RD0) || (rdState_q == RD1);
    assign rd_bank    = rdCurBank;
    assign rd_addr    = rdAddr_q;
    assign mem0_lock  = lock_q[0];
    assign mem1_lock  = lock_q[1];
    assign mem0_empty = empty_q[0];
    assign mem1_empty = empty_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrState_q  <= WR0;
            nextBank_q <= 1'b0;
            wrCnt_q[0] <= '0;
            wrCnt_q[1] <= '0;
        end else begin
            case (wrState_q)
                WR0, WR1: begin
                    if (wrFill) begin
                        wrCnt_q[nextBank_q] <= '0;
                        nextBank_q          <= ~nextBank_q;
                        if (lock_q[~nextBank_q]) wrState_q <= WRSTALL;
                        else                     wrState_q <= nextBank_q ? WR0 : WR1;
                    end else if (wrAccept) begin
                        wrCnt_q[nextBank_q] <= wrCnt_q[nextBank_q] + (AW+1)'(1);
                    end
                end
                WRSTALL: begin
                    if (!lock_q[nextBank_q]) wrState_q <= nextBank_q ? WR1 : WR0;
                end
                default: wrState_q <= WR0;
            endcase
        end
    end

    // Reader only ever waits on the expected bank, so banks drain in write order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdState_q <= RDIDLE;
            expBank_q <= 1'b0;
            rdAddr_q  <= '0;
        end else begin
            case (rdState_q)
                RDIDLE: begin
                    if (lock_q[expBank_q]) rdState_q <= expBank_q ? RD1 : RD0;
                end
                RD0, RD1: begin
                    if (rdPop) begin
                        rdAddr_q <= rdAddr_q + AW'(1);
                        if (rdDrain) begin
                            expBank_q <= ~rdCurBank;
                            if (lock_q[~rdCurBank]) rdState_q <= rdCurBank ? RD0 : RD1;
                            else                    rdState_q <= RDIDLE;
                        end
                    end
                end
                default: rdState_q <= RDIDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q  <= 2'b00;
            empty_q <= 2'b11;
        end else begin
            if (wrFill)   lock_q[nextBank_q]  <= 1'b1;
            if (wrAccept) empty_q[nextBank_q] <= 1'b0;
            if (rdDrain) begin
                lock_q[rdCurBank]  <= 1'b0;
                empty_q[rdCurBank] <= 1'b1;
            end
        end
    end

`ifdef PINGPONG_IDX_CHK_EN
    logic [DEPTH-1:0] map_q [2];
    logic             err_q;

    // A duplicate still counts toward the fill; the map restarts once the bank locks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map_q[0] <= '0;
            map_q[1] <= '0;
            err_q    <= 1'b0;
        end else if (wrAccept) begin
            if (map_q[nextBank_q][wr_idx]) err_q <= 1'b1;
            if (wrFill) map_q[nextBank_q]         <= '0;
            else        map_q[nextBank_q][wr_idx] <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unusedIdx;
    assign unusedIdx = ^wr_idx;
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_pingpong_bank_ctrl.sv
// Scoreboard bench for pingpong_bank_ctrl (DEPTH=4): accepted writes queue the expected pop,
// a negedge monitor checks every pop; directed checks cover locking, stalls, reset and err.
module tb_pingpong_bank_ctrl;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid;
    logic [AW-1:0] wr_idx;
    logic          wr_ready;
    logic          wr_bank;
    logic          rd_ready;
    logic          rd_valid;
    logic          rd_bank;
    logic [AW-1:0] rd_addr;
    logic          mem0_lock;
    logic          mem1_lock;
    logic          mem0_empty;
    logic          mem1_empty;
    logic          err;

    int          vectors     = 0;
    int          miscompares = 0;
    int          tbWrCount   = 0;
    logic [AW:0] sbQ[$];
    logic [AW:0] popExp;
    logic        expErr;

    pingpong_bank_ctrl #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_idx     (wr_idx),
        .wr_ready   (wr_ready),
        .wr_bank    (wr_bank),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_bank    (rd_bank),
        .rd_addr    (rd_addr),
        .mem0_lock  (mem0_lock),
        .mem1_lock  (mem1_lock),
        .mem0_empty (mem0_empty),
        .mem1_empty (mem1_empty),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Called one step after a rising edge; holds the write until it is accepted.
    task automatic applyStimulus(input logic [AW-1:0] idx);
        bit accepted;
        int bankExp;
        accepted = 1'b0;
        wr_valid = 1'b1;
        wr_idx   = idx;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            if (wr_ready) begin
                accepted = 1'b1;
                bankExp  = (tbWrCount / DEPTH) % 2;
                checkOutput("wr_bank", int'(wr_bank), bankExp);
                sbQ.push_back({1'(bankExp), AW'(tbWrCount % DEPTH)});
                tbWrCount++;
            end
            @(posedge clk);
            #1;
        end
        wr_valid = 1'b0;
        if (!accepted) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL wr_accept: got no acceptance in 50 cycles, expected acceptance");
        end
    endtask

    task automatic checkResetState();
        checkOutput("rst_wr_ready",   int'(wr_ready),   1);
        checkOutput("rst_wr_bank",    int'(wr_bank),    0);
        checkOutput("rst_rd_valid",   int'(rd_valid),   0);
        checkOutput("rst_rd_bank",    int'(rd_bank),    0);
        checkOutput("rst_rd_addr",    int'(rd_addr),    0);
        checkOutput("rst_mem0_lock",  int'(mem0_lock),  0);
        checkOutput("rst_mem1_lock",  int'(mem1_lock),  0);
        checkOutput("rst_mem0_empty", int'(mem0_empty), 1);
        checkOutput("rst_mem1_empty", int'(mem1_empty), 1);
        checkOutput("rst_err",        int'(err),        0);
    endtask

    task automatic pulseReset();
        #2 rst_n = 1'b0;
        #2 checkResetState();
        sbQ.delete();
        tbWrCount = 0;
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();
    endtask

    // Called one step after a rising edge; pops until every queued entry is consumed.
    task automatic drainQueue();
        bit done;
        done     = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (sbQ.size() == 0) done = 1'b1;
        end
        nextCycle();
        rd_ready = 1'b0;
        checkOutput("sb_drained", sbQ.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && rd_valid && rd_ready) begin
            vectors++;
            if (sbQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_pop: got bank %0d addr %0d, expected no pop",
                         rd_bank, rd_addr);
            end else begin
                popExp = sbQ.pop_front();
                if ({rd_bank, rd_addr} !== popExp) begin
                    miscompares++;
                    $display("[TB] FAIL rd_pop: got bank %0d addr %0d, expected bank %0d addr %0d",
                             rd_bank, rd_addr, popExp[AW], popExp[AW-1:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got time limit, expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
`ifdef PINGPONG_IDX_CHK_EN
        expErr = 1'b1;
`else
        expErr = 1'b0;
`endif
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_idx   = '0;
        rd_ready = 1'b0;
        #12 checkResetState();
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();

        $display("[TB] single bank fill with scrambled indices, then drain");
        applyStimulus(2'd3);
        applyStimulus(2'd1);
        applyStimulus(2'd0);
        applyStimulus(2'd2);
        @(negedge clk);
        checkOutput("t1_mem0_lock",  int'(mem0_lock),  1);
        checkOutput("t1_wr_bank",    int'(wr_bank),    1);
        checkOutput("t1_wr_ready",   int'(wr_ready),   1);
        checkOutput("t1_mem0_empty", int'(mem0_empty), 0);
        checkOutput("t1_rd_idle",    int'(rd_valid),   0);
        @(negedge clk);
        checkOutput("t1_rd_valid",   int'(rd_valid),   1);
        checkOutput("t1_rd_addr",    int'(rd_addr),    0);
        nextCycle();
        drainQueue();
        @(negedge clk);
        checkOutput("t1_unlock",     int'(mem0_lock),  0);
        checkOutput("t1_empty",      int'(mem0_empty), 1);
        checkOutput("t1_rd_done",    int'(rd_valid),   0);

        $display("[TB] fill both banks, stall, then back-to-back drain");
        pulseReset();
        for (int i = 0; i < 8; i++) applyStimulus(AW'(i % DEPTH));
        @(negedge clk);
        checkOutput("t2_stall_ready", int'(wr_ready),  0);
        checkOutput("t2_stall_bank",  int'(wr_bank),   0);
        checkOutput("t2_mem0_lock",   int'(mem0_lock), 1);
        checkOutput("t2_mem1_lock",   int'(mem1_lock), 1);
        checkOutput("t2_rd_valid",    int'(rd_valid),  1);
        checkOutput("t2_rd_bank",     int'(rd_bank),   0);
        nextCycle();
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("t2_rd_valid_cont", int'(rd_valid), 1);
            if (i == 4) begin
                checkOutput("t2_mem0_unlock", int'(mem0_lock), 0);
                checkOutput("t2_still_stall", int'(wr_ready),  0);
                checkOutput("t2_rd_bank1",    int'(rd_bank),   1);
            end
            if (i == 5) begin
                checkOutput("t2_resume_ready", int'(wr_ready), 1);
                checkOutput("t2_resume_bank",  int'(wr_bank),  0);
            end
        end
        nextCycle();
        rd_ready = 1'b0;
        @(negedge clk);
        checkOutput("t2_mem1_unlock", int'(mem1_lock),  0);
        checkOutput("t2_mem1_empty",  int'(mem1_empty), 1);
        checkOutput("t2_mem0_empty",  int'(mem0_empty), 1);
        checkOutput("t2_rd_done",     int'(rd_valid),   0);
        checkOutput("t2_sb_empty",    sbQ.size(),       0);

        $display("[TB] reset mid-frame with bank 0 locked and bank 1 partial");
        nextCycle();
        for (int i = 0; i < 6; i++) applyStimulus(AW'(i % DEPTH));
        @(negedge clk);
        checkOutput("t3_mem0_lock",  int'(mem0_lock),  1);
        checkOutput("t3_mem1_empty", int'(mem1_empty), 0);
        pulseReset();
        applyStimulus(2'd3);
        applyStimulus(2'd2);
        applyStimulus(2'd1);
        applyStimulus(2'd0);
        @(negedge clk);
        checkOutput("t3_relock0",    int'(mem0_lock), 1);
        checkOutput("t3_mem1_lock",  int'(mem1_lock), 0);
        checkOutput("t3_wr_bank",    int'(wr_bank),   1);
        nextCycle();
        drainQueue();

        $display("[TB] duplicate index in bank 1");
        applyStimulus(2'd2);
        @(negedge clk);
        checkOutput("t4_err_first", int'(err), 0);
        nextCycle();
        applyStimulus(2'd2);
        @(negedge clk);
        checkOutput("t4_err_dup", int'(err), int'(expErr));
        nextCycle();
        applyStimulus(2'd0);
        applyStimulus(2'd1);
        @(negedge clk);
        checkOutput("t4_err_sticky", int'(err),       int'(expErr));
        checkOutput("t4_mem1_lock",  int'(mem1_lock), 1);
        nextCycle();
        drainQueue();
        @(negedge clk);
        checkOutput("t4_err_hold", int'(err), int'(expErr));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pingpong_bank_ctrl.md
PINGPONG_BANK_CTRL -- requirements
Module: pingpong_bank_ctrl

Interface
- REQ-001 SHALL have parameter DEPTH, default 8, entries per bank (power of 2, >= 2).
- REQ-002 SHALL have parameter AW, default $clog2(DEPTH), bank address width.
- REQ-003 SHALL have port clk, input, 1, sole clock (rising edge).
- REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous assert, active-low.
- REQ-005 SHALL have port wr_valid, input, 1, write request.
- REQ-006 SHALL have port wr_idx, input, AW, reorder index of write (bank address).
- REQ-007 SHALL have port wr_ready, output, 1, write accepted when wr_valid && wr_ready.
- REQ-008 SHALL have port wr_bank, output, 1, bank targeted by the current write (0/1).
- REQ-009 SHALL have port rd_ready, input, 1, reader pop request.
- REQ-010 SHALL have port rd_valid, output, 1, read data available.
- REQ-011 SHALL have port rd_bank, output, 1, bank being read.
- REQ-012 SHALL have port rd_addr, output, AW, sequential read address.
- REQ-013 SHALL have ports mem0_lock and mem1_lock, output, 1 each, bank full and owned by the reader.
- REQ-014 SHALL have ports mem0_empty and mem1_empty, output, 1 each, bank holds no unread entries.
- REQ-015 SHALL have port err, output, 1, sticky error flag (see Configuration).

Function
- REQ-016 Write FSM SHALL be one-hot with states WR0, WR1, WRSTALL; wr_ready = WR0|WR1; wr_bank = 1 in WR1, otherwise last-filled bank's complement.
- REQ-017 Per-bank write counter (AW+1 bits) SHALL increment on each accepted write; on the DEPTH-th accepted write the counter clears and memX_lock SHALL be 1 from the next cycle.
- REQ-018 On filling bank X, write FSM SHALL go to the other bank's state if that bank's registered lock is 0, else to WRSTALL.
- REQ-019 WRSTALL SHALL leave to the awaited bank's state the cycle after that bank's lock reads 0; a same-cycle unlock is not bypassed (one stall cycle minimum).
- REQ-020 Write banks SHALL strictly alternate 0,1,0,1 from reset.
- REQ-021 Read FSM SHALL be one-hot with states RDIDLE, RD0, RD1; RDIDLE moves to RDn when memn_lock is 1, checking the expected bank only (strict alternation, starting at bank 0).
- REQ-022 rd_valid SHALL be 1 exactly in RD0/RD1; rd_bank = 1 in RD1; rd_addr = per-read counter, starting 0.
- REQ-023 On rd_valid && rd_ready, rd_addr SHALL increment; on the pop at rd_addr = DEPTH-1 it wraps to 0, that bank's lock clears and empty sets next cycle.
- REQ-024 After draining bank X, read FSM SHALL go directly to the other bank's state if its lock is 1 (no bubble), else RDIDLE.
- REQ-025 memX_empty SHALL be 0 from the first accepted write to bank X until its final pop; 1 otherwise.
- REQ-026 Writes to a locked bank SHALL be impossible (wr_ready = 0); pops with rd_valid = 0 SHALL be ignored.
- REQ-027 Write and read SHALL proceed concurrently on different banks in the same cycle.

Reset
- REQ-028 On rst_n = 0 SHALL immediately force: write FSM WR0, read FSM RDIDLE, all counters 0, lock = 0, empty = 1, err = 0.
- REQ-029 Reset mid-frame SHALL discard all partial and locked bank contents; first post-reset write targets bank 0.

Configuration
- REQ-030 Macro PINGPONG_IDX_CHK_EN defined: per-bank DEPTH-bit written map; err SHALL set sticky on an accepted write whose wr_idx is already marked in the current bank; map clears when the bank locks. Duplicate write still counts toward fill.
- REQ-031 Macro undefined: no map is built; err SHALL be tied to 0.

Verification (DEPTH=4)
- REQ-032 Write idx 3,1,0,2 to bank 0 -> mem0_lock = 1 next cycle, wr_bank = 1, wr_ready stays 1; reader pops rd_addr 0,1,2,3 from bank 0.
- REQ-033 Fill banks 0 and 1 with rd_ready = 0 -> wr_ready = 0 (WRSTALL); 4 pops from bank 0 -> mem0_lock = 0, then wr_ready = 1 one cycle later, wr_bank = 0.
- REQ-034 Both banks locked, rd_ready held 1 -> 8 consecutive pops, rd_bank 0 then 1, rd_valid never drops between banks.
- REQ-035 rst_n pulsed low after 2 writes to bank 1 -> all outputs at reset values that cycle; next 4 writes lock bank 0.
- REQ-036 With PINGPONG_IDX_CHK_EN: write idx 2,2 -> err = 1 after the second write and stays 1; without the macro -> err = 0.
